issue_sched: RTL and testbench

Dual-issue scheduler in front of the two FAB execution units. Buffers decoded ALU/branch instructions in a 4-entry in-order queue and issues up to two per cycle, in program order, to FAB port 0 (older) and port 1 (younger). It blocks issue on intra-pair and one-cycle-back register hazards, and turns a FAB-reported taken/mispredicted branch into a queue flush plus a registered fetch redirect. Load/store instructions never enter this block.

---
 rtl/issue_sched_pkg.sv | 53 +++++
 rtl/issue_queue.sv | 69 ++++++
 rtl/issue_sched.sv | 139 +++++++++++++
 tb/tb_issue_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_sched_pkg.sv
// issue_sched_pkg: shared types and helpers for the dual-issue scheduler.
// Decode bundle layout (LSB first): rfwsrc[1:0] rfwe[2] dmwidth[4:3] dmsign[5]
// dmwe[6] aluop[11:7] alusrc[12] npcop[15:13] extop[21:16] imm[53:22]
// rd[58:54] rt[63:59] rs[68:64] insttype[71:69].
package issue_sched_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DEC_W       = 72;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned NPCOP_W     = 3;
  localparam int unsigned ISSUE_DEPTH = 4;

  // Sequential next-PC; any other NPCop marks a control instruction.
  localparam logic [NPCOP_W-1:0] NPC_PLUS4 = 3'b000;

  // Decode bundle; member order fixes the bit offsets listed above.
  typedef struct packed {
    logic [2:0]         insttype;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [31:0]        imm;
    logic [5:0]         extop;
    logic [NPCOP_W-1:0] npcop;
    logic               alusrc;
    logic [4:0]         aluop;
    logic               dmwe;
    logic               dmsign;
    logic [1:0]         dmwidth;
    logic               rfwe;
    logic [1:0]         rfwsrc;
  } dec_t;

  // One queued instruction.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    dec_t            decode;
  } iq_entry_t;

  // True when r matches a valid busy destination register.
  function automatic logic busy_hit(input logic [1:0]            vld,
                                    input logic [1:0][REG_W-1:0] rd,
                                    input logic [REG_W-1:0]      r);
    return (vld[0] && (rd[0] == r)) || (vld[1] && (rd[1] == r));
  endfunction

  // An instruction produces a register result only with rfwe set and rd != x0.
  function automatic logic writes_rd(input logic rfwe, input logic [REG_W-1:0] rd);
    return rfwe && (rd != '0);
  endfunction

endpackage

// File: rtl/issue_queue.sv
// issue_queue: in-order circular buffer with 2-wide enqueue and dequeue.
// Ports: enq_valid (01 = one entry, 11 = two), enq_data0/1, deq_n (0..2),
// flush (empties the queue, dropping same-cycle enqueues), head0/head1 (oldest
// two entries), count (occupancy).
module issue_queue
  import issue_sched_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_DEPTH,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    enq_valid,
  input  iq_entry_t     enq_data0,
  input  iq_entry_t     enq_data1,
  input  logic [1:0]    deq_n,
  output iq_entry_t     head0,
  output iq_entry_t     head1,
  output logic [CW-1:0] count
);

  iq_entry_t     mem_q [DEPTH];
  iq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    enq_n;

  // Next-state: flush wins over any enqueue/dequeue in the same cycle.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    enq_n   = {enq_valid[0] & enq_valid[1], enq_valid[0] & ~enq_valid[1]};
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_valid[0]) mem_d[tail_q] = enq_data0;
      if (enq_valid[0] && enq_valid[1]) mem_d[PW'(tail_q + PW'(1))] = enq_data1;
      head_d  = PW'(head_q + PW'(deq_n));
      tail_d  = PW'(tail_q + PW'(enq_n));
      count_d = CW'(count_q + CW'(enq_n) - CW'(deq_n));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign head0 = mem_q[head_q];
  assign head1 = mem_q[PW'(head_q + PW'(1))];
  assign count = count_q;

endmodule

// File: rtl/issue_sched.sv
// issue_sched: dual-issue in-order scheduler feeding FAB ports 0 (older) and 1.
// Ports: in_valid/in_pc/in_npc/in_decode + in_ready (2-wide enqueue), stop
// (downstream stall), iss0_*/iss1_*/iss_valid (issue slots, zero when idle),
// br_flag/br_addr (FAB branch resolution), redirect_valid/redirect_pc
// (one-cycle registered fetch redirect).
module issue_sched
  import issue_sched_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in_valid,
  input  logic [2*XLEN-1:0]    in_pc,
  input  logic [2*XLEN-1:0]    in_npc,
  input  logic [2*DEC_W-1:0]   in_decode,
  output logic                 in_ready,
  input  logic                 stop,
  output logic [XLEN-1:0]      iss0_pc,
  output logic [XLEN-1:0]      iss0_npc,
  output logic [DEC_W-1:0]     iss0_decode,
  output logic                 iss0_num,
  output logic [XLEN-1:0]      iss1_pc,
  output logic [XLEN-1:0]      iss1_npc,
  output logic [DEC_W-1:0]     iss1_decode,
  output logic                 iss1_num,
  output logic [1:0]           iss_valid,
  input  logic [1:0]           br_flag,
  input  logic [2*XLEN-1:0]    br_addr,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [CW-1:0]         count;
  iq_entry_t             ent_a, ent_b, enq0, enq1;
  logic [1:0]            enq_valid, deq_n;
  logic                  a_iss, b_iss, a_wr, b_wr;
  logic                  flush;
  logic [XLEN-1:0]       flush_pc;

  logic [1:0]            busy_vld_q, busy_vld_d;
  logic [1:0][REG_W-1:0] busy_rd_q, busy_rd_d;
  logic                  seq_q, seq_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;

  // Ready needs room for a full pair and no redirect in flight.
  assign in_ready  = (count <= CW'(DEPTH - 2)) && !redirect_valid_q;
  assign enq_valid = in_ready ? in_valid : 2'b00;
  assign enq0      = {in_pc[XLEN-1:0], in_npc[XLEN-1:0], in_decode[DEC_W-1:0]};
  assign enq1      = {in_pc[2*XLEN-1:XLEN], in_npc[2*XLEN-1:XLEN], in_decode[2*DEC_W-1:DEC_W]};

  issue_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_data0 (enq0),
    .enq_data1 (enq1),
    .deq_n     (deq_n),
    .head0     (ent_a),
    .head1     (ent_b),
    .count     (count)
  );

  // Issue selection: A is the head, B may pair with it only if independent of A.
  always_comb begin
    a_iss = 1'b0;
    b_iss = 1'b0;
    a_wr  = writes_rd(ent_a.decode.rfwe, ent_a.decode.rd);
    b_wr  = writes_rd(ent_b.decode.rfwe, ent_b.decode.rd);
    if ((count >= CW'(1)) && !stop) begin
      a_iss = !busy_hit(busy_vld_q, busy_rd_q, ent_a.decode.rs) &&
              !busy_hit(busy_vld_q, busy_rd_q, ent_a.decode.rt);
    end
    if (a_iss && (count >= CW'(2))) begin
      b_iss = !busy_hit(busy_vld_q, busy_rd_q, ent_b.decode.rs) &&
              !busy_hit(busy_vld_q, busy_rd_q, ent_b.decode.rt) &&
              (ent_a.decode.npcop == NPC_PLUS4) &&
              !(a_wr && ((ent_b.decode.rs == ent_a.decode.rd) ||
                         (ent_b.decode.rt == ent_a.decode.rd))) &&
              !(a_wr && b_wr && (ent_a.decode.rd == ent_b.decode.rd));
    end
    // b_iss implies a_iss, so the sum is {b, a & ~b}.
    deq_n = {b_iss, a_iss & ~b_iss};
  end

  // Idle slots drive all-zero payloads.
  assign iss_valid   = {b_iss, a_iss};
  assign iss0_pc     = a_iss ? ent_a.pc : '0;
  assign iss0_npc    = a_iss ? ent_a.npc : '0;
  assign iss0_decode = a_iss ? ent_a.decode : '0;
  assign iss0_num    = a_iss & seq_q;
  assign iss1_pc     = b_iss ? ent_b.pc : '0;
  assign iss1_npc    = b_iss ? ent_b.npc : '0;
  assign iss1_decode = b_iss ? ent_b.decode : '0;
  assign iss1_num    = b_iss & ~seq_q;

  // Taken branch on an issued slot; the older slot wins.
  assign flush    = (a_iss && br_flag[0]) || (b_iss && br_flag[1]);
  assign flush_pc = (a_iss && br_flag[0]) ? br_addr[XLEN-1:0] : br_addr[2*XLEN-1:XLEN];

  // Busy set, sequence bit and redirect next-state.
  always_comb begin
    busy_vld_d       = busy_vld_q;
    busy_rd_d        = busy_rd_q;
    seq_d            = seq_q ^ (a_iss ^ b_iss);
    redirect_valid_d = flush;
    redirect_pc_d    = flush ? flush_pc : redirect_pc_q;
    // A stalled FAB keeps last cycle's producers in its pipeline register.
    if (!stop) begin
      busy_vld_d   = {b_iss & b_wr, a_iss & a_wr};
      busy_rd_d[0] = ent_a.decode.rd;
      busy_rd_d[1] = ent_b.decode.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vld_q       <= '0;
      busy_rd_q        <= '0;
      seq_q            <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      busy_vld_q       <= busy_vld_d;
      busy_rd_q        <= busy_rd_d;
      seq_q            <= seq_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed scenarios plus random traffic against a queue-based
// reference model of the scheduler's issue, hazard, flush and redirect rules.
module tb_issue_sched;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst, stop;
  logic [1:0]   in_valid;
  logic [63:0]  in_pc, in_npc;
  logic [143:0] in_decode;
  logic         in_ready;
  logic [31:0]  iss0_pc, iss0_npc, iss1_pc, iss1_npc;
  logic [71:0]  iss0_decode, iss1_decode;
  logic         iss0_num, iss1_num;
  logic [1:0]   iss_valid;
  logic [1:0]   br_flag;
  logic [63:0]  br_addr;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;

  always #5 clk = ~clk;

  issue_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc),
    .in_decode(in_decode), .in_ready(in_ready), .stop(stop),
    .iss0_pc(iss0_pc), .iss0_npc(iss0_npc), .iss0_decode(iss0_decode), .iss0_num(iss0_num),
    .iss1_pc(iss1_pc), .iss1_npc(iss1_npc), .iss1_decode(iss1_decode), .iss1_num(iss1_num),
    .iss_valid(iss_valid), .br_flag(br_flag), .br_addr(br_addr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [71:0] dec;
  } ent_t;

  // Reference model state.
  ent_t        mq[$];
  logic [4:0]  mbusy[$];
  logic        mseq, mrv;
  logic [31:0] mrpc;

  int n_chk = 0;
  int n_err = 0;

  // Last observed DUT values, for scenario-specific checks.
  logic [1:0]  obs_iv;
  logic        obs_rdy, obs_rv;
  logic [31:0] obs_rpc;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] f_rd(input logic [71:0] d); return d[58:54]; endfunction
  function automatic logic [4:0] f_rt(input logic [71:0] d); return d[63:59]; endfunction
  function automatic logic [4:0] f_rs(input logic [71:0] d); return d[68:64]; endfunction
  function automatic logic       f_we(input logic [71:0] d); return d[2];      endfunction
  function automatic logic [2:0] f_np(input logic [71:0] d); return d[15:13];  endfunction

  function automatic logic busy_has(input logic [4:0] r);
    foreach (mbusy[i]) if (mbusy[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  // Random bundle with chosen register/control fields.
  function automatic logic [71:0] mk(input int rd, input int rs, input int rt,
                                     input logic we, input logic [2:0] np);
    logic [71:0] d;
    d = {8'($urandom), $urandom, $urandom};
    d[58:54] = 5'(rd);
    d[63:59] = 5'(rt);
    d[68:64] = 5'(rs);
    d[2]     = we;
    d[15:13] = np;
    return d;
  endfunction

  function automatic logic [71:0] rnd_dec();
    logic [2:0] np;
    np = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
    return mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom), np);
  endfunction

  // One clock: drive at negedge, check against the model, advance the model.
  task automatic step(input logic r, input logic st, input logic [1:0] iv,
                      input logic [71:0] d0, input logic [71:0] d1,
                      input logic [1:0] bf, input logic [31:0] ba0);
    int cnt;
    logic a_i, b_i, aw, bw, fl, rdy;
    logic [31:0] fpc;
    ent_t A, B;
    logic [63:0] pcs, npcs, ba;
    pcs  = {$urandom, $urandom};
    npcs = {$urandom, $urandom};
    ba   = {$urandom, ba0};
    @(negedge clk);
    rst = r; stop = st; in_valid = iv; in_pc = pcs; in_npc = npcs;
    in_decode = {d1, d0}; br_flag = bf; br_addr = ba;
    #1;
    cnt = mq.size();
    rdy = (cnt <= DEPTH - 2) && !mrv;
    a_i = 1'b0; b_i = 1'b0; aw = 1'b0; bw = 1'b0;
    A = '{pc: 32'h0, npc: 32'h0, dec: 72'h0};
    B = A;
    if (cnt >= 1) begin A = mq[0]; aw = f_we(A.dec) && (f_rd(A.dec) != 5'd0); end
    if (cnt >= 2) begin B = mq[1]; bw = f_we(B.dec) && (f_rd(B.dec) != 5'd0); end
    if (cnt >= 1 && !st) a_i = !busy_has(f_rs(A.dec)) && !busy_has(f_rt(A.dec));
    if (a_i && cnt >= 2)
      b_i = !busy_has(f_rs(B.dec)) && !busy_has(f_rt(B.dec)) && (f_np(A.dec) == 3'b000) &&
            !(aw && (f_rs(B.dec) == f_rd(A.dec) || f_rt(B.dec) == f_rd(A.dec))) &&
            !(aw && bw && f_rd(A.dec) == f_rd(B.dec));
    fl  = (a_i && bf[0]) || (b_i && bf[1]);
    fpc = (a_i && bf[0]) ? ba[31:0] : ba[63:32];

    chk("iss_valid", 144'(iss_valid), 144'({b_i, a_i}));
    chk("iss0", 144'({iss0_pc, iss0_npc, iss0_decode, iss0_num}),
        a_i ? 144'({A.pc, A.npc, A.dec, mseq}) : 144'(0));
    chk("iss1", 144'({iss1_pc, iss1_npc, iss1_decode, iss1_num}),
        b_i ? 144'({B.pc, B.npc, B.dec, ~mseq}) : 144'(0));
    chk("in_ready", 144'(in_ready), 144'(rdy));
    chk("redirect", 144'({redirect_valid, redirect_pc}), 144'({mrv, mrpc}));
    obs_iv = iss_valid; obs_rdy = in_ready; obs_rv = redirect_valid; obs_rpc = redirect_pc;

    @(posedge clk);
    if (r) begin
      mq.delete(); mbusy.delete(); mseq = 1'b0; mrv = 1'b0; mrpc = 32'h0;
    end else begin
      if (a_i) void'(mq.pop_front());
      if (b_i) void'(mq.pop_front());
      if (fl) mq.delete();
      else if (rdy && iv[0]) begin
        mq.push_back('{pc: pcs[31:0], npc: npcs[31:0], dec: d0});
        if (iv[1]) mq.push_back('{pc: pcs[63:32], npc: npcs[63:32], dec: d1});
      end
      if (!st) begin
        mbusy.delete();
        if (a_i && aw) mbusy.push_back(f_rd(A.dec));
        if (b_i && bw) mbusy.push_back(f_rd(B.dec));
      end
      mseq = mseq ^ a_i ^ b_i;
      mrv  = fl;
      if (fl) mrpc = fpc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 72'h0, 72'h0, 2'b00, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stop = 1'b0; in_valid = 2'b00; in_pc = '0; in_npc = '0;
    in_decode = '0; br_flag = 2'b00; br_addr = '0;
    mseq = 1'b0; mrv = 1'b0; mrpc = 32'h0;
    repeat (2) @(posedge clk);

    // Reset state.
    idle(1);
    chk("rst_iv", 144'(obs_iv), 144'(0));
    chk("rst_rdy", 144'(obs_rdy), 144'(1));
    chk("rst_rv", 144'(obs_rv), 144'(0));

    // Independent pair issues together.
    step(0, 0, 2'b11, mk(1, 3, 4, 1, 0), mk(2, 5, 6, 1, 0), 2'b00, 0);
    idle(1);
    chk("pair_iv", 144'(obs_iv), 144'(2'b11));
    idle(2);

    // Intra-pair RAW: older issues alone, younger waits out the busy window.
    step(0, 0, 2'b11, mk(5, 7, 7, 1, 0), mk(6, 5, 7, 1, 0), 2'b00, 0);
    idle(1);
    chk("raw_iv0", 144'(obs_iv), 144'(2'b01));
    idle(1);
    chk("raw_iv1", 144'(obs_iv), 144'(2'b00));
    idle(1);
    chk("raw_iv2", 144'(obs_iv), 144'(2'b01));
    idle(2);

    // Taken branch in slot 0: flush, redirect, and dropped enqueues.
    step(0, 0, 2'b11, mk(0, 1, 2, 0, 3'b001), mk(3, 1, 1, 1, 0), 2'b00, 0);
    step(0, 0, 2'b11, mk(4, 1, 1, 1, 0), mk(5, 1, 1, 1, 0), 2'b01, 32'h100);
    chk("br_iv", 144'(obs_iv), 144'(2'b01));
    step(0, 0, 2'b11, mk(4, 1, 1, 1, 0), mk(5, 1, 1, 1, 0), 2'b00, 0);
    chk("br_rv", 144'(obs_rv), 144'(1));
    chk("br_rpc", 144'(obs_rpc), 144'(32'h100));
    chk("br_rdy", 144'(obs_rdy), 144'(0));
    idle(1);
    chk("br_drop", 144'(obs_iv), 144'(0));
    chk("br_rv_off", 144'(obs_rv), 144'(0));
    idle(1);

    // Fill under stop, then drain.
    step(0, 1, 2'b11, mk(1, 0, 0, 1, 0), mk(2, 0, 0, 1, 0), 2'b00, 0);
    step(0, 1, 2'b11, mk(3, 0, 0, 1, 0), mk(4, 0, 0, 1, 0), 2'b00, 0);
    step(0, 1, 2'b00, 72'h0, 72'h0, 2'b00, 0);
    chk("fill_rdy", 144'(obs_rdy), 144'(0));
    idle(1);
    chk("fill_iv", 144'(obs_iv), 144'(2'b11));
    chk("fill_rdy_deq", 144'(obs_rdy), 144'(0));
    idle(1);
    chk("fill_rdy_back", 144'(obs_rdy), 144'(1));
    idle(2);

    // Stop during a busy window.
    step(0, 0, 2'b11, mk(5, 0, 0, 1, 0), mk(6, 5, 0, 1, 0), 2'b00, 0);
    idle(1);
    step(0, 1, 2'b00, 72'h0, 72'h0, 2'b00, 0);
    step(0, 1, 2'b00, 72'h0, 72'h0, 2'b00, 0);
    idle(3);

    // Reset with three entries queued.
    step(0, 1, 2'b11, mk(1, 0, 0, 1, 0), mk(2, 0, 0, 1, 0), 2'b00, 0);
    step(0, 1, 2'b01, mk(3, 0, 0, 1, 0), 72'h0, 2'b00, 0);
    step(1, 1, 2'b00, 72'h0, 72'h0, 2'b00, 0);
    idle(1);
    chk("mr_iv", 144'(obs_iv), 144'(0));
    chk("mr_rdy", 144'(obs_rdy), 144'(1));
    chk("mr_rv", 144'(obs_rv), 144'(0));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] iv, bf;
      case ($urandom_range(0, 2))
        0:       iv = 2'b00;
        1:       iv = 2'b01;
        default: iv = 2'b11;
      endcase
      bf[0] = ($urandom_range(0, 5) == 0);
      bf[1] = ($urandom_range(0, 5) == 0);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0), iv,
           rnd_dec(), rnd_dec(), bf, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
